// File: rtl/time_sync_ctrl.sv
// time_sync_ctrl: requests host time over UART ("T?\n"), awaits the parser,
// range-checks and loads clock counters. Option: TIME_SYNC_UNSOLICITED_EN.
module time_sync_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int RESYNC_S   = 3600,
  parameter int TIMEOUT_MS = 500,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       p_rst,
  input  logic       p_synced,
  input  logic [4:0] p_hour,
  input  logic [5:0] p_min,
  input  logic [5:0] p_sec,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int IW = $clog2(RESYNC_S + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_TX0,
    S_TX1,
    S_TX2,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0] presc;
  logic [IW-1:0] ivl;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [4:0] cap_h, cap_h_nx, hold_h;
  logic [5:0] cap_m, cap_m_nx, hold_m;
  logic [5:0] cap_s, cap_s_nx, hold_s;
  logic       locked_nx, fail_nx;
  logic [3:0] retry_nx, retry_inc;
  logic       unsol_q, unsol_nx;
  logic       load_c, p_rst_c, tx_valid_c;
  logic [7:0] tx_data_c;
  logic       ivl_clr, att_fail;
  logic       tick, expiry, chk_ok;

  assign tick   = presc == PW'(CLK_HZ - 1);
  assign expiry = tick && (ivl == IW'(RESYNC_S - 1));
  assign chk_ok = (cap_h <= 5'd23) && (cap_m <= 6'd59)
               && (cap_s <= 6'd59);
  assign retry_inc = retry_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      ivl   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (ivl_clr)
        ivl <= '0;
      else if (tick)
        ivl <= expiry ? '0 : ivl + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLR;
      tcnt      <= '0;
      cap_h     <= '0;
      cap_m     <= '0;
      cap_s     <= '0;
      hold_h    <= '0;
      hold_m    <= '0;
      hold_s    <= '0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      unsol_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      cap_h     <= cap_h_nx;
      cap_m     <= cap_m_nx;
      cap_s     <= cap_s_nx;
      locked    <= locked_nx;
      fail      <= fail_nx;
      retry_cnt <= retry_nx;
      unsol_q   <= unsol_nx;
      if (load_c) begin
        hold_h <= cap_h;
        hold_m <= cap_m;
        hold_s <= cap_s;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    tcnt_nx    = tcnt;
    cap_h_nx   = cap_h;
    cap_m_nx   = cap_m;
    cap_s_nx   = cap_s;
    locked_nx  = locked;
    fail_nx    = fail;
    retry_nx   = retry_cnt;
    unsol_nx   = unsol_q;
    load_c     = 1'b0;
    p_rst_c    = 1'b0;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    ivl_clr    = 1'b0;
    att_fail   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start || expiry) begin
          retry_nx = '0;
          state_nx = S_CLR;
        end
`ifdef TIME_SYNC_UNSOLICITED_EN
        else if (p_synced) begin
          cap_h_nx = p_hour;
          cap_m_nx = p_min;
          cap_s_nx = p_sec;
          unsol_nx = 1'b1;
          state_nx = S_CHECK;
        end
`endif
      end
      S_CLR: begin
        p_rst_c  = 1'b1;
        state_nx = S_TX0;
      end
      S_TX0: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'h54;
        if (tx_ready) state_nx = S_TX1;
      end
      S_TX1: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'h3F;
        if (tx_ready) state_nx = S_TX2;
      end
      S_TX2: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'h0A;
        if (tx_ready) begin
          tcnt_nx  = '0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // a frame landing in the expiry cycle still counts
        if (p_synced) begin
          cap_h_nx = p_hour;
          cap_m_nx = p_min;
          cap_s_nx = p_sec;
          unsol_nx = 1'b0;
          state_nx = S_CHECK;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          att_fail = 1'b1;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      S_CHECK: begin
        unsol_nx = 1'b0;
        if (chk_ok) begin
          load_c    = 1'b1;
          locked_nx = 1'b1;
          fail_nx   = 1'b0;
          retry_nx  = '0;
          ivl_clr   = unsol_q;
          state_nx  = S_IDLE;
        end else if (unsol_q) begin
          state_nx = S_IDLE;
        end else begin
          att_fail = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (att_fail) begin
      retry_nx = retry_inc;
      if (retry_inc < 4'(MAX_RETRY)) begin
        state_nx = S_CLR;
      end else begin
        fail_nx   = 1'b1;
        locked_nx = 1'b0;
        state_nx  = S_IDLE;
      end
    end
  end

  assign p_rst     = p_rst_c & ~rst;
  assign tx_valid  = tx_valid_c & ~rst;
  assign tx_data   = rst ? 8'h00 : tx_data_c;
  assign load      = load_c & ~rst;
  assign load_hour = load ? cap_h : hold_h;
  assign load_min  = load ? cap_m : hold_m;
  assign load_sec  = load ? cap_s : hold_s;

endmodule

// File: tb/tb_time_sync_ctrl.sv
// tb_time_sync_ctrl: directed stimulus, per-cycle check against a
// transaction-level model of the sync protocol, plus literal spot checks.
module tb_time_sync_ctrl;

  localparam int CLK_HZ     = 1000;
  localparam int RESYNC_S   = 2;
  localparam int TIMEOUT_MS = 10;
  localparam int MAX_RETRY  = 3;
  localparam int T_CYC      = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int PERIOD     = CLK_HZ * RESYNC_S;

  logic       clk;
  logic       rst;
  logic       start;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       p_rst;
  logic       p_synced;
  logic [4:0] p_hour;
  logic [5:0] p_min;
  logic [5:0] p_sec;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;

  time_sync_ctrl #(
    .CLK_HZ(CLK_HZ),
    .RESYNC_S(RESYNC_S),
    .TIMEOUT_MS(TIMEOUT_MS),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .p_rst(p_rst),
    .p_synced(p_synced),
    .p_hour(p_hour),
    .p_min(p_min),
    .p_sec(p_sec),
    .load(load),
    .load_hour(load_hour),
    .load_min(load_min),
    .load_sec(load_sec),
    .locked(locked),
    .fail(fail),
    .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_cyc  = 0;

  always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  // model state: what the outputs must be in the current cycle
  bit         m_p_rst, m_tx_valid, m_load, m_locked, m_fail;
  logic [7:0] m_tx_data;
  int         m_retry;
  logic [4:0] m_cap_h, m_held_h;
  logic [5:0] m_cap_m, m_held_m, m_cap_s, m_held_s;
  bit         mrst, last_rst, expd;
  int         k;
  logic       st_s, rdy_s, syn_s;
  logic [4:0] h_s;
  logic [5:0] mi_s, se_s;
  logic [7:0] req_b [3];

  task automatic adv();
    @(posedge clk);
    st_s  = start;
    rdy_s = tx_ready;
    syn_s = p_synced;
    h_s   = p_hour;
    mi_s  = p_min;
    se_s  = p_sec;
    last_rst = rst;
    expd = !rst && ((k % PERIOD) == PERIOD - 1);
    if (rst) begin
      mrst = 1'b1;
      k = 0;
    end else begin
      k++;
    end
  endtask

  task automatic attempts();
    bit done, got, ok;
    done = 1'b0;
    while (!done) begin
      m_p_rst = 1'b1;
      adv();
      m_p_rst = 1'b0;
      if (mrst) return;
      for (int b = 0; b < 3; b++) begin
        m_tx_valid = 1'b1;
        m_tx_data  = req_b[b];
        do begin
          adv();
          if (mrst) return;
        end while (!rdy_s);
      end
      m_tx_valid = 1'b0;
      m_tx_data  = 8'h00;
      got = 1'b0;
      for (int w = 0; w < T_CYC && !got; w++) begin
        adv();
        if (mrst) return;
        if (syn_s) begin
          got = 1'b1;
          m_cap_h = h_s;
          m_cap_m = mi_s;
          m_cap_s = se_s;
        end
      end
      ok = got && m_cap_h <= 23 && m_cap_m <= 59 && m_cap_s <= 59;
      if (got) begin
        m_load = ok;
        adv();
        m_load = 1'b0;
        if (mrst) return;
      end
      if (ok) begin
        m_held_h = m_cap_h;
        m_held_m = m_cap_m;
        m_held_s = m_cap_s;
        m_locked = 1'b1;
        m_fail   = 1'b0;
        m_retry  = 0;
        done     = 1'b1;
      end else begin
        m_retry++;
        if (m_retry >= MAX_RETRY) begin
          m_fail   = 1'b1;
          m_locked = 1'b0;
          done     = 1'b1;
        end
      end
    end
  endtask

  initial begin : model
    req_b[0] = 8'h54;
    req_b[1] = 8'h3F;
    req_b[2] = 8'h0A;
    mrst = 1'b0;
    last_rst = 1'b0;
    k = 0;
    while (!mrst) adv();
    forever begin
      mrst = 1'b0;
      m_p_rst = 0; m_tx_valid = 0; m_tx_data = 0; m_load = 0;
      m_locked = 0; m_fail = 0; m_retry = 0;
      m_cap_h = 0; m_cap_m = 0; m_cap_s = 0;
      m_held_h = 0; m_held_m = 0; m_held_s = 0;
      attempts();
      while (!mrst) begin
        adv();
        if (!mrst && (st_s || expd)) begin
          m_retry = 0;
          attempts();
        end
      end
    end
  end

  task automatic cmp_cycle();
    logic [34:0] act, req;
    if (!rst || last_rst) begin
      act = {p_rst, tx_valid, tx_data, load, load_hour, load_min,
             load_sec, locked, fail, retry_cnt};
      if (rst)
        req = '0;
      else
        req = {m_p_rst, m_tx_valid, m_tx_data, m_load,
               m_load ? m_cap_h : m_held_h,
               m_load ? m_cap_m : m_held_m,
               m_load ? m_cap_s : m_held_s,
               m_locked, m_fail, 4'(m_retry)};
      n_tests++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h",
                 $time, act, req);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string nm, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic to_wait0();
    int n;
    n = 0;
    while (!(tx_valid && tx_data == 8'h0A) && n < 40) begin
      step();
      n++;
    end
    lit("reach_tx2", 64'(n < 40), 1);
    step();
  endtask

  task automatic answer(logic [4:0] h, logic [5:0] m, logic [5:0] s,
                        int dly);
    to_wait0();
    repeat (dly) step();
    p_hour = h;
    p_min = m;
    p_sec = s;
    p_synced = 1'b1;
    step();
    p_synced = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int nl, nr;
    rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b1;
    p_synced = 1'b0;
    p_hour = '0;
    p_min = '0;
    p_sec = '0;
    repeat (3) step();
    lit("rst_outs", {p_rst, tx_valid, load, locked, fail, retry_cnt}, 0);

    rst = 1'b0;
    #1;
    lit("first_p_rst", {p_rst, tx_valid}, 2'b10);
    step();
    lit("byte_T", {tx_valid, tx_data}, {1'b1, 8'h54});
    step();
    lit("byte_q", {tx_valid, tx_data}, {1'b1, 8'h3F});
    step();
    lit("byte_nl", {tx_valid, tx_data}, {1'b1, 8'h0A});
    step();
    lit("wait_idle_tx", tx_valid, 0);
    p_hour = 5'd12; p_min = 6'd34; p_sec = 6'd56;
    p_synced = 1'b1;
    step();
    p_synced = 1'b0;
    lit("load_123456", {load, load_hour, load_min, load_sec},
        {1'b1, 5'd12, 6'd34, 6'd56});
    step();
    lit("locked_hold", {load, locked, load_hour}, {1'b0, 1'b1, 5'd12});

    start = 1'b1;
    step();
    start = 1'b0;
    lit("start_p_rst", p_rst, 1);
    step();
    step();
    tx_ready = 1'b0;
    step();
    step();
    lit("stall_q", {tx_valid, tx_data}, {1'b1, 8'h3F});
    step();
    tx_ready = 1'b1;
    lit("stall_q_end", {tx_valid, tx_data}, {1'b1, 8'h3F});
    step();
    lit("after_stall_nl", {tx_valid, tx_data}, {1'b1, 8'h0A});
    step();
    step();
    p_hour = 5'd1; p_min = 6'd2; p_sec = 6'd3;
    p_synced = 1'b1;
    step();
    p_synced = 1'b0;
    lit("load_010203", {load, load_hour, load_min, load_sec},
        {1'b1, 5'd1, 6'd2, 6'd3});

    step();
    p_hour = 5'd5; p_min = 6'd6; p_sec = 6'd7;
    p_synced = 1'b1;
    step();
    p_synced = 1'b0;
    step();
    lit("idle_synced_ignored", {load, load_hour, p_rst}, {1'b0, 5'd1, 1'b0});

    start = 1'b1;
    step();
    start = 1'b0;
    nl = 0;
    repeat (50) begin
      step();
      nl += int'(load);
    end
    lit("timeouts_no_load", nl, 0);
    lit("timeouts_fail", {fail, locked, retry_cnt}, {1'b1, 1'b0, 4'd3});

    start = 1'b1;
    step();
    start = 1'b0;
    lit("retry_cleared", {fail, retry_cnt}, {1'b1, 4'd0});
    answer(5'd24, 6'd0, 6'd0, 0);
    lit("bad_no_load", load, 0);
    step();
    lit("retry_one", {p_rst, retry_cnt, load}, {1'b1, 4'd1, 1'b0});
    answer(5'd23, 6'd59, 6'd59, T_CYC - 1);
    lit("load_235959", {load, load_hour, load_min, load_sec},
        {1'b1, 5'd23, 6'd59, 6'd59});
    step();
    lit("relocked", {locked, fail, retry_cnt}, {1'b1, 1'b0, 4'd0});

    while (tb_cyc < PERIOD - 1) step();
    lit("pre_expiry", {p_rst, tx_valid}, 0);
    step();
    lit("expiry_req", p_rst, 1);
    to_wait0();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    p_hour = 5'd10; p_min = 6'd20; p_sec = 6'd30;
    p_synced = 1'b1;
    step();
    p_synced = 1'b0;
    lit("load_102030", {load, load_hour, load_min, load_sec},
        {1'b1, 5'd10, 6'd20, 6'd30});
    nr = 0;
    repeat (20) begin
      step();
      nr += int'(p_rst);
    end
    lit("start_in_wait_dropped", nr, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    lit("pre_rst_tx1", {tx_valid, tx_data}, {1'b1, 8'h3F});
    rst = 1'b1;
    step();
    lit("rst_mid_all_zero",
        {p_rst, tx_valid, tx_data, load, load_hour, load_min,
         load_sec, locked, fail, retry_cnt}, 0);
    rst = 1'b0;
    #1;
    lit("rst_mid_restart", p_rst, 1);
    answer(5'd8, 6'd9, 6'd10, 0);
    lit("load_080910", {load, load_hour, load_min, load_sec},
        {1'b1, 5'd8, 6'd9, 6'd10});
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
